uart_receive: RTL and testbench

Serial-to-parallel UART receiver; the downstream counterpart of the transmitter on the same 100 MHz clock. Recovers 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) from the asynchronous `UART_Rx` line. Uses the same bit period as the transmitter: 10000 clocks, 10 kbaud. Presents each byte on a level valid/ack handshake and flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_receive.sv | 136 +++++++++++++
 tb/tb_uart_receive.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the 10 kbaud bit period
// also used by the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_CLKS_PER_BIT_10K = 10000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous receive line.
// Both flops reset to the idle level 1. rx_fall is high in the first cycle rx_s reads 0.
module uart_rx_sync (
  input  logic Clk_100M,
  input  logic Reset,
  input  logic rx_async,
  output logic rx_s,
  output logic rx_fall
);

  logic meta;

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      meta    <= 1'b1;
      rx_s    <= 1'b1;
      rx_fall <= 1'b0;
    end else begin
      meta    <= rx_async;
      rx_s    <= meta;
      rx_fall <= rx_s & ~meta;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// UART 8N1 receiver: start bit, 8 data bits LSB first, stop bit; byte presented on a
// level valid/ack handshake. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_receive
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_10K
) (
  input  logic                      Clk_100M,
  input  logic                      Reset,
  input  logic                      UART_Rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      data_valid,
  input  logic                      data_ack,
  output logic                      busy,
  output logic                      framing_err,
  output logic                      overrun
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(UART_DATA_BITS);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic                      rx_fall;
  logic                      sample;
  uart_rx_state_e            state;
  uart_rx_state_e            state_nx;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      cnt_clr;
  logic                      bit_tick;
  logic                      stop_good;
  logic                      stop_bad;

  uart_rx_sync u_sync (
    .Clk_100M (Clk_100M),
    .Reset    (Reset),
    .rx_async (UART_Rx),
    .rx_s     (rx_s),
    .rx_fall  (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // The window is nominal-1..nominal+1, so every decision lands one cycle after nominal.
  localparam logic [CW-1:0] CNT_START = CW'(HALF);
  logic [1:0] hist;

  always_ff @(posedge Clk_100M) begin
    if (Reset) hist <= 2'b11;
    else       hist <= {hist[0], rx_s};
  end

  assign sample = maj3(hist[1], hist[0], rx_s);
`else
  localparam logic [CW-1:0] CNT_START = CW'(HALF - 1);

  assign sample = rx_s;
`endif

  always_ff @(posedge Clk_100M) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // rx_fall marks the usual edge; the level term also catches a line already low at reset release.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rx_fall || !rx_s) state_nx = START;
      START:   if (cnt == CNT_START) state_nx = sample ? IDLE : DATA;
      DATA:    if (cnt == CNT_LAST && bit_idx == IDX_LAST) state_nx = STOP;
      STOP:    if (cnt == CNT_LAST) state_nx = sample ? IDLE : BREAK;
      BREAK:   if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b0;
    bit_tick  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  cnt_clr = 1'b1;
      START: cnt_clr = (cnt == CNT_START);
      DATA:  bit_tick = (cnt == CNT_LAST);
      STOP: begin
        stop_good = (cnt == CNT_LAST) &&  sample;
        stop_bad  = (cnt == CNT_LAST) && !sample;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= (cnt_clr || cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      if (state == IDLE) begin
        bit_idx <= '0;
      end else if (bit_tick) begin
        shreg[bit_idx] <= sample;
        bit_idx        <= bit_idx + IW'(1);
      end
    end
  end

  // Handshake: data_valid is a level; the consumer takes data in any cycle it sees data_valid
  // high by raising data_ack, and data_valid drops the next cycle. A byte completing in the
  // same cycle as the ack reloads data and keeps data_valid high; ack without valid is ignored.
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      data        <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= stop_bad;
      overrun     <= stop_good && data_valid && !data_ack;
      if (stop_good) begin
        data       <= shreg;
        data_valid <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive at CLKS_PER_BIT=16: directed scenarios plus random
// frames, all outputs compared every cycle against a frame-schedule model of the receiver.
module tb_uart_receive;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  // ---------------- clock / reset ----------------
  logic       Clk_100M = 1'b0;
  logic       Reset    = 1'b1;
  logic       UART_Rx  = 1'b1;
  logic       dir_ack  = 1'b0;
  logic       rand_bit = 1'b0;
  logic       rand_ack_en = 1'b0;
  wire        data_ack = dir_ack | (rand_ack_en & rand_bit);
  logic [7:0] data;
  logic       data_valid;
  logic       busy;
  logic       framing_err;
  logic       overrun;

  always #5 Clk_100M = ~Clk_100M;

  uart_receive #(.CLKS_PER_BIT(CPB)) dut (
    .Clk_100M    (Clk_100M),
    .Reset       (Reset),
    .UART_Rx     (UART_Rx),
    .data        (data),
    .data_valid  (data_valid),
    .data_ack    (data_ack),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int fall_cyc = 0;

  // ---------------- reference model ----------------
  // Line seen by the receiver is UART_Rx two cycles late; a frame is defined by its first low
  // cycle t0 and every decision falls at a fixed offset from t0.
  typedef enum {M_IDLE, M_FRAME, M_BREAK} mmode_e;
  mmode_e     mode = M_IDLE;
  bit         model_ok = 1'b0;
  logic       m1 = 1'b1, m2 = 1'b1;
  logic       h0 = 1'b1, h1 = 1'b1, h2 = 1'b1;
  logic       smp, ack_clr;
  logic       exp_load = 1'b0;
  int         t0 = 0, e = 0, k = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0, exp_busy = 1'b0, exp_fe = 1'b0, exp_ovr = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] want;

  always @(posedge Clk_100M) begin
    cyc++;
    h2 = h1; h1 = h0; h0 = m2;
    smp = (D == 1) ? ((h2 & h1) | (h2 & h0) | (h1 & h0)) : h0;
    exp_load = 1'b0;
    if (Reset) begin
      exp_data = 8'h00; exp_valid = 1'b0; exp_busy = 1'b0; exp_fe = 1'b0; exp_ovr = 1'b0;
      mode = M_IDLE; m1 = 1'b1; m2 = 1'b1; h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
      model_ok = 1'b1;
    end else begin
      exp_fe  = 1'b0;
      exp_ovr = 1'b0;
      ack_clr = data_ack && exp_valid;
      case (mode)
        M_IDLE: if (!h0) begin mode = M_FRAME; t0 = cyc; end
        M_FRAME: begin
          e = cyc - t0;
          if (e == HALF + D) begin
            if (smp) mode = M_IDLE;
          end else if (e > HALF + D && ((e - HALF - D) % CPB) == 0) begin
            k = (e - HALF - D) / CPB - 1;
            if (k < 8) rx_byte[k] = smp;
            else if (smp) begin exp_load = 1'b1; mode = M_IDLE; end
            else begin exp_fe = 1'b1; mode = M_BREAK; end
          end
        end
        M_BREAK: if (h0) mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
      if (exp_load) begin
        exp_ovr   = exp_valid && !data_ack;
        exp_data  = rx_byte;
        exp_valid = 1'b1;
      end else if (ack_clr) begin
        exp_valid = 1'b0;
      end
      exp_busy = (mode != M_IDLE);
      m2 = m1; m1 = UART_Rx;
    end
  end

  always @(negedge Clk_100M) rand_bit = ($urandom_range(0, 3) == 0);

  // ---------------- compare process / scoreboard ----------------
  always @(negedge Clk_100M) begin
    if (model_ok) begin
      n_checks++;
      if (data !== exp_data || data_valid !== exp_valid || busy !== exp_busy ||
          framing_err !== exp_fe || overrun !== exp_ovr) begin
        n_errors++;
        $display("FAIL cycle_compare cyc=%0d got data=%h v=%b busy=%b fe=%b ovr=%b want data=%h v=%b busy=%b fe=%b ovr=%b",
                 cyc, data, data_valid, busy, framing_err, overrun,
                 exp_data, exp_valid, exp_busy, exp_fe, exp_ovr);
      end
      if (exp_load) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL scoreboard cyc=%0d got byte %h want none queued", cyc, exp_data);
        end else begin
          want = exp_q.pop_front();
          if (want !== exp_data) begin
            n_errors++;
            $display("FAIL scoreboard cyc=%0d got byte %h want %h", cyc, exp_data, want);
          end
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge Clk_100M);
  endtask

  task automatic align();
    @(posedge Clk_100M);
    #1;
  endtask

  task automatic idle(input int n);
    UART_Rx = 1'b1;
    repeat (n) begin @(posedge Clk_100M); #1; end
  endtask

  task automatic pulse_ack();
    @(negedge Clk_100M); dir_ack = 1'b1;
    @(negedge Clk_100M); dir_ack = 1'b0;
  endtask

  // Called just after a rising edge; drives ncyc cycles of a frame, glitch_at inverts one cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int glitch_at, input int ncyc);
    logic bv;
    for (int i = 0; i < ncyc; i++) begin
      if (i == 0) fall_cyc = cyc;
      if (i < CPB)           bv = 1'b0;
      else if (i < 9 * CPB)  bv = b[i / CPB - 1];
      else                   bv = stop_bit;
      UART_Rx = (i == glitch_at) ? ~bv : bv;
      @(posedge Clk_100M);
      #1;
    end
  endtask

  task automatic send_full(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1, -1, 10 * CPB);
  endtask

  // ---------------- stimulus ----------------
  int f;
  logic [7:0] rb;
  logic       rs;

  initial begin
    repeat (3) @(posedge Clk_100M);
    #1 Reset = 1'b0;
    @(negedge Clk_100M);
    chk8("reset_data", data, 8'h00);
    chk1("reset_valid", data_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_fe", framing_err, 1'b0);
    chk1("reset_ovr", overrun, 1'b0);

    // 1: single frame, exact latency, then ack
    align(); idle(5);
    f = cyc;
    fork
      send_full(8'hA5);
      begin
        wait_until(f + 154 + D);
        chk1("t1_valid_before", data_valid, 1'b0);
        wait_until(f + 155 + D);
        chk1("t1_valid", data_valid, 1'b1);
        chk8("t1_data", data, 8'hA5);
        chk1("t1_busy_low", busy, 1'b0);
      end
    join
    pulse_ack();
    chk1("t1_ack_clears", data_valid, 1'b0);

    // 2: 3-cycle low glitch
    align(); idle(5);
    f = cyc;
    UART_Rx = 1'b0;
    repeat (3) begin @(posedge Clk_100M); #1; end
    UART_Rx = 1'b1;
    wait_until(f + 10 + D);
    chk1("t2_busy_at_check", busy, 1'b1);
    wait_until(f + 11 + D);
    chk1("t2_idle_again", busy, 1'b0);
    chk1("t2_no_valid", data_valid, 1'b0);

    // 3: bad stop with held break, then recovery
    align(); idle(5);
    f = cyc;
    fork
      send_frame(8'h00, 1'b0, -1, 10 * CPB);
      begin
        wait_until(f + 155 + D);
        chk1("t3_framing_err", framing_err, 1'b1);
        chk1("t3_no_valid", data_valid, 1'b0);
      end
    join
    repeat (40) begin @(posedge Clk_100M); #1; end
    @(negedge Clk_100M);
    chk1("t3_busy_in_break", busy, 1'b1);
    align(); idle(10);
    @(negedge Clk_100M);
    chk1("t3_busy_released", busy, 1'b0);
    align();
    send_full(8'h81);
    @(negedge Clk_100M);
    chk8("t3_data_81", data, 8'h81);
    pulse_ack();

    // 4: back-to-back with overrun, then with ack at the second completion
    align(); idle(3);
    f = cyc;
    fork
      begin send_full(8'h3C); send_full(8'hC3); end
      begin
        wait_until(f + 155 + D);
        chk1("t4_first_no_ovr", overrun, 1'b0);
        wait_until(f + 160 + 155 + D);
        chk1("t4_overrun", overrun, 1'b1);
        chk8("t4_data_c3", data, 8'hC3);
        chk1("t4_valid_kept", data_valid, 1'b1);
      end
    join
    pulse_ack();
    align(); idle(3);
    f = cyc;
    fork
      begin send_full(8'h3C); send_full(8'hC3); end
      begin
        wait_until(f + 160 + 154 + D);
        dir_ack = 1'b1;
        wait_until(f + 160 + 155 + D);
        dir_ack = 1'b0;
        chk1("t4b_no_overrun", overrun, 1'b0);
        chk1("t4b_valid", data_valid, 1'b1);
        chk8("t4b_data_c3", data, 8'hC3);
      end
    join

    // 5: reset during data bit 4
    align(); idle(3);
    send_frame(8'h5A, 1'b1, -1, 85);
    UART_Rx = 1'b1;
    Reset = 1'b1;
    @(posedge Clk_100M);
    #1 Reset = 1'b0;
    @(negedge Clk_100M);
    chk8("t5_reset_data", data, 8'h00);
    chk1("t5_reset_valid", data_valid, 1'b0);
    chk1("t5_reset_busy", busy, 1'b0);
    align(); idle(5);
    send_full(8'h5A);
    @(negedge Clk_100M);
    chk8("t5_data_5a", data, 8'h5A);
    pulse_ack();

    // 6: one-cycle glitch at bit 2's nominal sample
    align(); idle(5);
    want = (D == 1) ? 8'hFF : 8'hFB;
    exp_q.push_back(want);
    send_frame(8'hFF, 1'b1, 56, 10 * CPB);
    @(negedge Clk_100M);
    chk8("t6_glitch_data", data, want);
    pulse_ack();

    // random frames with random acks
    align(); idle(5);
    rand_ack_en = 1'b1;
    for (int n = 0; n < 14; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 5) != 0);
      if (rs) exp_q.push_back(rb);
      send_frame(rb, rs, -1, 10 * CPB);
      if (!rs) begin
        UART_Rx = 1'b0;
        repeat ($urandom_range(0, 20)) begin @(posedge Clk_100M); #1; end
        idle($urandom_range(1, 25));
      end else begin
        idle($urandom_range(0, 25));
      end
    end
    rand_ack_en = 1'b0;
    idle(20);
    @(negedge Clk_100M);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got %0d bytes left want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
